// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter -- round-robin sharing of one async SRAM between an emulated
// EPROM target (reads) and a host loader (reads/writes).   Rev 1.0
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_WIDTH    = 18,
  parameter int DATA_WIDTH    = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tgt_req,
  input  logic [ADDR_WIDTH-1:0] tgt_addr,
  output logic [DATA_WIDTH-1:0] tgt_data,
  output logic                  tgt_ack,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_ack,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_WIDTH-1:0] sram_dq_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR       = 3'd3,
    WR_HOLD  = 3'd4,
    ACK      = 3'd5
  } state_t;

  localparam logic [3:0] C_CNT_LAST = 4'(ACCESS_CYCLES - 1);

  state_t     r_state, w_state_next;
  logic [3:0] r_cnt;
  logic       r_last_host, r_win_host;
  logic       w_grant, w_grant_host, w_cnt_done;
  logic       w_ce_n, w_oe_n, w_we_n, w_dq_oe;

  assign w_cnt_done   = (r_cnt == C_CNT_LAST);
  // With both pending, the side not served last time wins.
  assign w_grant_host = host_req && (!tgt_req || !r_last_host);
  assign busy         = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (tgt_req || host_req) begin
          w_grant      = 1'b1;
          w_state_next = (w_grant_host && host_we) ? WR_SETUP : RD;
        end
      end
      RD:       if (w_cnt_done) w_state_next = ACK;
      WR_SETUP: w_state_next = WR;
      WR:       if (w_cnt_done) w_state_next = WR_HOLD;
      WR_HOLD:  w_state_next = ACK;
      ACK:      w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase

    // Strobes are decoded from the next state so the registered pins line up
    // with the state they belong to.
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_dq_oe = 1'b0;
    case (w_state_next)
      RD:       begin w_ce_n = 1'b0; w_oe_n = 1'b0; end
      WR_SETUP: begin w_ce_n = 1'b0; w_dq_oe = 1'b1; end
      WR:       begin w_ce_n = 1'b0; w_dq_oe = 1'b1; w_we_n = 1'b0; end
      WR_HOLD:  begin w_ce_n = 1'b0; w_dq_oe = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_last_host <= 1'b1;
      r_win_host  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_o   <= '0;
      tgt_data    <= '0;
      host_rdata  <= '0;
      tgt_ack     <= 1'b0;
      host_ack    <= 1'b0;
    end else begin
      sram_ce_n  <= w_ce_n;
      sram_oe_n  <= w_oe_n;
      sram_we_n  <= w_we_n;
      sram_dq_oe <= w_dq_oe;
      tgt_ack    <= (w_state_next == ACK) && !r_win_host;
      host_ack   <= (w_state_next == ACK) &&  r_win_host;

      if (w_state_next != r_state)
        r_cnt <= '0;
      else if ((r_state == RD || r_state == WR) && !w_cnt_done)
        r_cnt <= r_cnt + 4'd1;

      if (w_grant) begin
        r_win_host  <= w_grant_host;
        r_last_host <= w_grant_host;
        sram_addr   <= w_grant_host ? host_addr : tgt_addr;
        if (w_grant_host && host_we)
          sram_dq_o <= host_wdata;
      end

      if (r_state == RD && w_cnt_done) begin
        if (r_win_host) host_rdata <= sram_dq_i;
        else            tgt_data   <= sram_dq_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_arbiter -- directed stimulus with a queue scoreboard per DUT.  Rev 1.0
// ============================================================================
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_host;
    bit          is_wr;
    logic [7:0]  data;
    int          lat;
    int          issue;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  // DUT A: ACCESS_CYCLES = 2
  logic          tgt_req_a = 1'b0, host_req_a = 1'b0, host_we_a = 1'b0;
  logic [AW-1:0] tgt_addr_a = '0, host_addr_a = '0;
  logic [DW-1:0] host_wdata_a = '0;
  logic [DW-1:0] tgt_data_a, host_rdata_a, dq_o_a, dq_i_a;
  logic          tgt_ack_a, host_ack_a, dq_oe_a, ce_n_a, oe_n_a, we_n_a, busy_a;
  logic [AW-1:0] addr_a;

  // DUT B: ACCESS_CYCLES = 1
  logic          tgt_req_b = 1'b0, host_req_b = 1'b0, host_we_b = 1'b0;
  logic [AW-1:0] tgt_addr_b = '0, host_addr_b = '0;
  logic [DW-1:0] host_wdata_b = '0;
  logic [DW-1:0] tgt_data_b, host_rdata_b, dq_o_b, dq_i_b;
  logic          tgt_ack_b, host_ack_b, dq_oe_b, ce_n_b, oe_n_b, we_n_b, busy_b;
  logic [AW-1:0] addr_b;

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];

  assign dq_i_a = (!ce_n_a && !oe_n_a) ? mem_a[addr_a] : '0;
  assign dq_i_b = (!ce_n_b && !oe_n_b) ? mem_b[addr_b] : '0;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .tgt_req(tgt_req_a), .tgt_addr(tgt_addr_a), .tgt_data(tgt_data_a), .tgt_ack(tgt_ack_a),
    .host_req(host_req_a), .host_we(host_we_a), .host_addr(host_addr_a),
    .host_wdata(host_wdata_a), .host_rdata(host_rdata_a), .host_ack(host_ack_a),
    .sram_addr(addr_a), .sram_dq_o(dq_o_a), .sram_dq_oe(dq_oe_a), .sram_dq_i(dq_i_a),
    .sram_ce_n(ce_n_a), .sram_oe_n(oe_n_a), .sram_we_n(we_n_a), .busy(busy_a)
  );

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCESS_CYCLES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .tgt_req(tgt_req_b), .tgt_addr(tgt_addr_b), .tgt_data(tgt_data_b), .tgt_ack(tgt_ack_b),
    .host_req(host_req_b), .host_we(host_we_b), .host_addr(host_addr_b),
    .host_wdata(host_wdata_b), .host_rdata(host_rdata_b), .host_ack(host_ack_b),
    .sram_addr(addr_b), .sram_dq_o(dq_o_b), .sram_dq_oe(dq_oe_b), .sram_dq_i(dq_i_b),
    .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  logic [7:0] mdl_tgt_a = '0, mdl_host_a = '0, mdl_tgt_b = '0, mdl_host_b = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_tgt_a = '0;
      mdl_host_a = '0;
    end else begin
      chk("a_invariants", {29'd0, (!we_n_a && !oe_n_a), (!oe_n_a && dq_oe_a),
                           (tgt_ack_a && host_ack_a)}, 32'd0);
      if (tgt_ack_a || host_ack_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_ack", {30'd0, tgt_ack_a, host_ack_a}, 32'd0);
        end else begin
          e_a = q_a.pop_front();
          chk("a_ack_port", {31'd0, host_ack_a}, {31'd0, e_a.is_host});
          if (e_a.lat >= 0) chk("a_latency", cyc - e_a.issue, e_a.lat);
          if (!e_a.is_host)    mdl_tgt_a  = e_a.data;
          else if (!e_a.is_wr) mdl_host_a = e_a.data;
          chk("a_tgt_data", {24'd0, tgt_data_a}, {24'd0, mdl_tgt_a});
          chk("a_host_rdata", {24'd0, host_rdata_a}, {24'd0, mdl_host_a});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_tgt_b = '0;
      mdl_host_b = '0;
    end else begin
      chk("b_invariants", {29'd0, (!we_n_b && !oe_n_b), (!oe_n_b && dq_oe_b),
                           (tgt_ack_b && host_ack_b)}, 32'd0);
      if (tgt_ack_b || host_ack_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_ack", {30'd0, tgt_ack_b, host_ack_b}, 32'd0);
        end else begin
          e_b = q_b.pop_front();
          chk("b_ack_port", {31'd0, host_ack_b}, {31'd0, e_b.is_host});
          if (e_b.lat >= 0) chk("b_latency", cyc - e_b.issue, e_b.lat);
          if (!e_b.is_host)    mdl_tgt_b  = e_b.data;
          else if (!e_b.is_wr) mdl_host_b = e_b.data;
          chk("b_host_rdata", {24'd0, host_rdata_b}, {24'd0, mdl_host_b});
        end
      end
    end
  end

  // SRAM A strobe tracker; the model only commits a full-width write pulse.
  int oe_low = 0, we_low = 0, last_oe_w = 0, last_we_w = 0;
  bit we_setup_ok = 1'b0, we_hold_ok = 1'b0;
  bit prev_dq_oe = 1'b0, prev_we_n = 1'b1, prev_ce_n = 1'b1;

  always @(negedge clk) begin
    if (!oe_n_a) oe_low++;
    else if (oe_low > 0) begin last_oe_w = oe_low; oe_low = 0; end
    if (!we_n_a && !ce_n_a) begin
      if (we_low == 0) we_setup_ok = prev_dq_oe && prev_we_n && !prev_ce_n;
      we_low++;
    end else if (we_low > 0) begin
      last_we_w  = we_low;
      we_hold_ok = dq_oe_a && !ce_n_a;
      if (we_low >= 2 && !ce_n_a && dq_oe_a) mem_a[addr_a] = dq_o_a;
      we_low = 0;
    end
    prev_dq_oe = dq_oe_a;
    prev_we_n  = we_n_a;
    prev_ce_n  = ce_n_a;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_a(input bit h, input bit w, input logic [7:0] d, input int lat);
    exp_t e;
    e.is_host = h; e.is_wr = w; e.data = d; e.lat = lat; e.issue = cyc;
    q_a.push_back(e);
  endtask

  task automatic push_b(input bit h, input bit w, input logic [7:0] d, input int lat);
    exp_t e;
    e.is_host = h; e.is_wr = w; e.data = d; e.lat = lat; e.issue = cyc;
    q_b.push_back(e);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 50; i++) begin
      if (!busy_a) return;
      @(negedge clk); #1;
    end
    chk("a_idle_timeout", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && q_a.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (q_a.size() != 0) begin
      chk("a_ack_timeout", q_a.size(), 32'd0);
      q_a.delete();
    end
  endtask

  task automatic wait_done_b(input int budget);
    for (int i = 0; i < budget && q_b.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (q_b.size() != 0) begin
      chk("b_ack_timeout", q_b.size(), 32'd0);
      q_b.delete();
    end
  endtask

  task automatic tgt_read_a(input logic [AW-1:0] ad, input logic [7:0] d);
    wait_idle_a();
    tgt_addr_a = ad;
    tgt_req_a  = 1'b1;
    push_a(1'b0, 1'b0, d, 3);
    wait_done_a(20);
    tgt_req_a = 1'b0;
  endtask

  task automatic host_op_a(input bit w, input logic [AW-1:0] ad, input logic [7:0] wd,
                           input logic [7:0] d, input int lat);
    wait_idle_a();
    host_we_a    = w;
    host_addr_a  = ad;
    host_wdata_a = wd;
    host_req_a   = 1'b1;
    push_a(1'b1, w, d, lat);
    wait_done_a(20);
    host_req_a = 1'b0;
    host_we_a  = 1'b0;
  endtask

  task automatic chk_reset_a();
    chk("rst_ce_n", {31'd0, ce_n_a}, 32'd1);
    chk("rst_oe_n", {31'd0, oe_n_a}, 32'd1);
    chk("rst_we_n", {31'd0, we_n_a}, 32'd1);
    chk("rst_dq_oe", {31'd0, dq_oe_a}, 32'd0);
    chk("rst_addr", {14'd0, addr_a}, 32'd0);
    chk("rst_dq_o", {24'd0, dq_o_a}, 32'd0);
    chk("rst_tgt_data", {24'd0, tgt_data_a}, 32'd0);
    chk("rst_host_rdata", {24'd0, host_rdata_a}, 32'd0);
    chk("rst_tgt_ack", {31'd0, tgt_ack_a}, 32'd0);
    chk("rst_host_ack", {31'd0, host_ack_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_a[18'h00100] = 8'hA5;
    mem_a[18'h00200] = 8'h3C;
    mem_a[18'h00300] = 8'h11;
    mem_a[18'h3FFFF] = 8'h00;
    mem_b[18'h00444] = 8'hC3;
    mem_b[18'h00555] = 8'h99;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_a();
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Both held from reset: target, host, target, host.
    tgt_addr_a  = 18'h00100;
    host_addr_a = 18'h00200;
    host_we_a   = 1'b0;
    tgt_req_a   = 1'b1;
    host_req_a  = 1'b1;
    push_a(1'b0, 1'b0, 8'hA5, 3);
    push_a(1'b1, 1'b0, 8'h3C, -1);
    push_a(1'b0, 1'b0, 8'hA5, -1);
    push_a(1'b1, 1'b0, 8'h3C, -1);
    wait_done_a(60);
    tgt_req_a  = 1'b0;
    host_req_a = 1'b0;

    // Single target read: oe_n low for exactly two clocks.
    tgt_read_a(18'h00100, 8'hA5);
    chk("a_oe_width", last_oe_w, 32'd2);

    // Host write at the top address, then read it back.
    host_op_a(1'b1, 18'h3FFFF, 8'h5A, 8'h00, 5);
    chk("a_mem_written", {24'd0, mem_a[18'h3FFFF]}, 32'h5A);
    chk("a_we_width", last_we_w, 32'd2);
    chk("a_we_setup", {31'd0, we_setup_ok}, 32'd1);
    chk("a_we_hold", {31'd0, we_hold_ok}, 32'd1);
    host_op_a(1'b0, 18'h3FFFF, 8'h00, 8'h5A, 3);
    tgt_read_a(18'h00200, 8'h3C);

    // Reset asserted while we_n is low aborts the write without an ack.
    wait_idle_a();
    host_addr_a  = 18'h00300;
    host_wdata_a = 8'h77;
    host_we_a    = 1'b1;
    host_req_a   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("a_we_low_in_wr", {31'd0, we_n_a}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("a_we_async_high", {31'd0, we_n_a}, 32'd1);
    chk("a_ce_async_high", {31'd0, ce_n_a}, 32'd1);
    chk("a_dq_oe_async_low", {31'd0, dq_oe_a}, 32'd0);
    host_req_a = 1'b0;
    host_we_a  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_a();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("a_no_partial_write", {24'd0, mem_a[18'h00300]}, 32'h11);

    // First access after reset is arbitrated fresh: target wins.
    wait_idle_a();
    tgt_addr_a  = 18'h3FFFF;
    host_addr_a = 18'h00100;
    tgt_req_a   = 1'b1;
    host_req_a  = 1'b1;
    push_a(1'b0, 1'b0, 8'h5A, 3);
    push_a(1'b1, 1'b0, 8'hA5, -1);
    wait_done_a(40);
    tgt_req_a  = 1'b0;
    host_req_a = 1'b0;

    // ACCESS_CYCLES=1 host read with the address changing during RD.
    @(negedge clk); #1;
    chk("b_idle", {31'd0, busy_b}, 32'd0);
    host_addr_b = 18'h00444;
    host_we_b   = 1'b0;
    host_req_b  = 1'b1;
    push_b(1'b1, 1'b0, 8'hC3, 2);
    @(posedge clk);
    #2;
    chk("b_oe_in_rd", {31'd0, oe_n_b}, 32'd0);
    host_addr_b = 18'h00555;
    #1;
    chk("b_addr_held", {14'd0, addr_b}, 32'h00444);
    wait_done_b(10);
    host_req_b = 1'b0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
